// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file write port between the pipeline writeback (A) and a buffered
// long-latency result stream (B), and tracks long-op destinations to stall decode on hazards.
module regfile_wb_arbiter #(
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_we,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    output logic        a_hold,
    input  logic        b_valid,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    output logic        b_ready,
    input  logic        iss_valid,
    input  logic        iss_long,
    input  logic [4:0]  iss_rs,
    input  logic [4:0]  iss_rt,
    input  logic [4:0]  iss_rd,
    output logic        iss_stall,
    output logic        rf_we,
    output logic [4:0]  rf_a3,
    output logic [31:0] rf_wd3,
    output logic [31:0] busy_vec
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned StW  = $clog2(STARVE_LIMIT) + 1;
    localparam logic [CntW-1:0] FullCnt   = CntW'(FIFO_DEPTH);
    localparam logic [StW-1:0]  StarveMax = StW'(STARVE_LIMIT - 1);

    logic [4:0]      fifo_addr_q [FIFO_DEPTH];
    logic [31:0]     fifo_data_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [StW-1:0]  starve_q, starve_d;
    logic            a_hold_q, a_hold_d;
    logic            rf_we_q, rf_we_d;
    logic [4:0]      rf_a3_q, rf_a3_d;
    logic [31:0]     rf_wd3_q, rf_wd3_d;
    logic [31:0]     busy_q, busy_d;

    logic            empty, push, pop, grant_a, stall;
    logic [4:0]      head_addr;
    logic [31:0]     head_data;

    assign empty     = (count_q == '0);
    assign b_ready   = (count_q != FullCnt);
    assign push      = b_valid & b_ready;
    assign head_addr = fifo_addr_q[rd_ptr_q];
    assign head_data = fifo_data_q[rd_ptr_q];

    // A pending hold forces the FIFO head through regardless of the pipeline request.
    always_comb begin
        grant_a = 1'b0;
        pop     = 1'b0;
        if (a_hold_q) begin
            pop = 1'b1;
        end else if (a_we && (a_addr != 5'd0)) begin
            grant_a = 1'b1;
        end else if (!empty) begin
            pop = 1'b1;
        end
    end

    always_comb begin
        rf_we_d  = 1'b0;
        rf_a3_d  = rf_a3_q;
        rf_wd3_d = rf_wd3_q;
        if (grant_a) begin
            rf_we_d  = 1'b1;
            rf_a3_d  = a_addr;
            rf_wd3_d = a_data;
        end else if (pop) begin
            rf_we_d  = (head_addr != 5'd0);
            rf_a3_d  = head_addr;
            rf_wd3_d = head_data;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d  = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        a_hold_d = 1'b0;
        if (pop) begin
            starve_d = '0;
        end else if (!empty) begin
            if (starve_q == StarveMax) begin
                a_hold_d = 1'b1;
                starve_d = '0;
            end else begin
                starve_d = starve_q + StW'(1);
            end
        end
    end

    assign stall = iss_valid & (busy_q[iss_rs] | busy_q[iss_rt] | busy_q[iss_rd]);

    // Set is applied after clear so a same-cycle reissue keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        if (pop) begin
            busy_d[head_addr] = 1'b0;
        end
        if (iss_valid && iss_long && !stall && (iss_rd != 5'd0)) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            a_hold_q <= 1'b0;
            rf_we_q  <= 1'b0;
            rf_a3_q  <= '0;
            rf_wd3_q <= '0;
            busy_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            a_hold_q <= a_hold_d;
            rf_we_q  <= rf_we_d;
            rf_a3_q  <= rf_a3_d;
            rf_wd3_q <= rf_wd3_d;
            busy_q   <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= b_addr;
            fifo_data_q[wr_ptr_q] <= b_data;
        end
    end

    assign a_hold    = a_hold_q;
    assign iss_stall = stall;
    assign rf_we     = rf_we_q;
    assign rf_a3     = rf_a3_q;
    assign rf_wd3    = rf_wd3_q;
    assign busy_vec  = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a queue-based reference model predicts every
// register-file write, hold, stall and busy bit; a monitor checks writes as they appear.
module tb_regfile_wb_arbiter;

    localparam int unsigned FIFO_DEPTH   = 2;
    localparam int unsigned STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_we, b_valid, iss_valid, iss_long;
    logic [4:0]  a_addr, b_addr, iss_rs, iss_rt, iss_rd;
    logic [31:0] a_data, b_data;
    logic        a_hold, b_ready, iss_stall, rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd3, busy_vec;

    regfile_wb_arbiter #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .a_we     (a_we),
        .a_addr   (a_addr),
        .a_data   (a_data),
        .a_hold   (a_hold),
        .b_valid  (b_valid),
        .b_addr   (b_addr),
        .b_data   (b_data),
        .b_ready  (b_ready),
        .iss_valid(iss_valid),
        .iss_long (iss_long),
        .iss_rs   (iss_rs),
        .iss_rt   (iss_rt),
        .iss_rd   (iss_rd),
        .iss_stall(iss_stall),
        .rf_we    (rf_we),
        .rf_a3    (rf_a3),
        .rf_wd3   (rf_wd3),
        .busy_vec (busy_vec)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned stamp;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    wr_t   exp_q[$];
    ent_t  m_fifo[$];
    logic [31:0] m_busy = '0;
    logic  m_hold = 1'b0;
    int    m_wait = 0;
    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Each write appears the cycle after its grant; compare it with the oldest prediction.
    always @(negedge clk) begin
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].stamp < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_write at cycle %0d: got none expected a%0d=%h",
                         cyc, exp_q[0].addr, exp_q[0].data);
                void'(exp_q.pop_front());
            end
            if (rf_we === 1'b1) begin
                if (exp_q.size() > 0 && exp_q[0].stamp == cyc) begin
                    wr_t w;
                    w = exp_q.pop_front();
                    chk("rf_a3", {27'd0, rf_a3}, {27'd0, w.addr});
                    chk("rf_wd3", rf_wd3, w.data);
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_write at cycle %0d: got a%0d=%h expected none",
                             cyc, rf_a3, rf_wd3);
                end
            end
        end
    end

    // Reference model for the coming edge, from the current inputs and model state.
    task automatic model_edge(input logic stall_exp);
        bit   popped = 0;
        bit   was_nonempty;
        bit   do_push;
        ent_t e;
        if (reset) begin
            m_fifo.delete();
            m_busy = '0;
            m_hold = 1'b0;
            m_wait = 0;
            return;
        end
        was_nonempty = (m_fifo.size() > 0);
        do_push = b_valid && (m_fifo.size() < FIFO_DEPTH);
        if (m_hold) begin
            popped = 1;
        end else if (a_we && a_addr != 5'd0) begin
            exp_q.push_back('{stamp: cyc + 1, addr: a_addr, data: a_data});
        end else if (was_nonempty) begin
            popped = 1;
        end
        if (popped) begin
            e = m_fifo.pop_front();
            if (e.addr != 5'd0) exp_q.push_back('{stamp: cyc + 1, addr: e.addr, data: e.data});
            m_busy[e.addr] = 1'b0;
        end
        m_hold = 1'b0;
        if (popped) begin
            m_wait = 0;
        end else if (was_nonempty) begin
            if (m_wait == STARVE_LIMIT - 1) begin
                m_hold = 1'b1;
                m_wait = 0;
            end else begin
                m_wait++;
            end
        end
        if (iss_valid && iss_long && !stall_exp && iss_rd != 5'd0) m_busy[iss_rd] = 1'b1;
        m_busy[0] = 1'b0;
        if (do_push) m_fifo.push_back('{addr: b_addr, data: b_data});
    endtask

    task automatic step();
        logic stall_exp;
        #1;
        stall_exp = iss_valid && (m_busy[iss_rs] || m_busy[iss_rt] || m_busy[iss_rd]);
        if (!reset) chk("iss_stall", {31'd0, iss_stall}, {31'd0, stall_exp});
        model_edge(stall_exp);
        @(negedge clk);
        mon_en = 1'b1;
        chk("a_hold", {31'd0, a_hold}, {31'd0, m_hold});
        chk("b_ready", {31'd0, b_ready}, {31'd0, m_fifo.size() < FIFO_DEPTH});
        chk("busy_vec", busy_vec, m_busy);
    endtask

    task automatic idle();
        reset = 0; a_we = 0; a_addr = 0; a_data = 0; b_valid = 0; b_addr = 0; b_data = 0;
        iss_valid = 0; iss_long = 0; iss_rs = 0; iss_rt = 0; iss_rd = 0;
    endtask

    task automatic push_b(input logic [4:0] addr, input logic [31:0] data);
        b_valid = 1; b_addr = addr; b_data = data;
    endtask

    initial begin
        idle();
        reset = 1;
        push_b(5'd3, 32'hBAD0_0003);
        step();
        step();
        idle();
        step();

        // Pipeline-only writes, including the ignored address-0 request.
        a_we = 1; a_addr = 5'd5; a_data = 32'hDEAD_BEEF;
        step();
        a_addr = 5'd0; a_data = 32'h1234_5678;
        step();
        idle();
        step();

        // Idle pipeline: a buffered result drains immediately.
        push_b(5'd7, 32'h11);
        step();
        idle();
        repeat (4) step();

        // Continuous pipeline traffic starves B until a hold forces it through.
        a_we = 1;
        push_b(5'd7, 32'h11);
        a_addr = 5'($urandom_range(1, 31)); a_data = $urandom;
        step();
        b_valid = 0;
        repeat (8) begin
            a_addr = 5'($urandom_range(1, 31));
            a_data = $urandom;
            step();
        end
        idle();
        step();

        // Scoreboard: long op to r9, dependent stall, release on completion, rd=0 ignored.
        iss_valid = 1; iss_long = 1; iss_rd = 5'd9; iss_rs = 5'd1; iss_rt = 5'd2;
        step();
        iss_long = 0; iss_rs = 5'd9; iss_rd = 5'd10;
        repeat (2) step();
        push_b(5'd9, 32'h9999_0009);
        step();
        b_valid = 0;
        repeat (3) step();
        iss_long = 1; iss_rs = 5'd0; iss_rt = 5'd0; iss_rd = 5'd0;
        step();
        idle();
        step();

        // Fill the FIFO under continuous pipeline writes; the third offer is refused.
        a_we = 1; a_addr = 5'd20; a_data = 32'hA0A0_0020;
        push_b(5'd3, 32'h0000_0003);
        step();
        push_b(5'd4, 32'h0000_0004);
        step();
        push_b(5'd5, 32'h0000_0005);
        step();
        b_valid = 0;
        repeat (12) step();
        // Reset with one entry queued: it must never reach the register file.
        push_b(5'd6, 32'h0000_0006);
        step();
        b_valid = 0;
        step();
        reset = 1;
        step();
        idle();
        repeat (6) step();

        repeat (3000) begin
            reset     = ($urandom_range(0, 199) == 0);
            a_we      = ($urandom_range(0, 9) < 7);
            a_addr    = 5'($urandom_range(0, 31));
            a_data    = $urandom;
            b_valid   = ($urandom_range(0, 9) < 4);
            b_addr    = 5'($urandom_range(0, 31));
            b_data    = $urandom;
            iss_valid = $urandom_range(0, 1) == 1;
            iss_long  = ($urandom_range(0, 9) < 3);
            iss_rs    = 5'($urandom_range(0, 31));
            iss_rt    = 5'($urandom_range(0, 31));
            iss_rd    = 5'($urandom_range(0, 31));
            step();
        end

        idle();
        repeat (10) step();
        chk("exp_queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
